// File: rtl/fifo_seq_pkg.sv
// Shared types and default widths for the delay-FIFO sequencer.
//   state_t   : controller states (IDLE, FILL, FULL, DRAIN, SCRUB)
//   DEF_DEPTH : default FIFO depth
//   DEF_BITS  : default word width
package fifo_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_FULL  = 3'd2,
        S_DRAIN = 3'd3,
        S_SCRUB = 3'd4
    } state_t;

    localparam int DEF_DEPTH = 8;
    localparam int DEF_BITS  = 64;

endpackage

// File: rtl/fifo_seq_ctrl.sv
// Upstream sequencer for a flagless delay FIFO lane.
// Accepts words over valid/ready, shifts them into the FIFO, tracks occupancy,
// drains exactly DEPTH words on start, or zero-fills the FIFO on scrub.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready/in_data     upstream word interface
//   start, scrub           single-cycle command pulses
//   fifo_en, fifo_d        FIFO shift enable and write data
//   fifo_q                 FIFO oldest entry (combinational from FIFO)
//   out_valid/out_ready/out_data  downstream drained word interface
//   count                  occupancy 0..DEPTH
//   busy                   DRAIN or SCRUB in progress
//   done                   pulse on the final drain/scrub beat
//   csum, csum_valid       XOR checksum of the drain (FIFO_SEQ_CSUM_EN only)
//
// Build option: define FIFO_SEQ_CSUM_EN to add the drain checksum outputs.
module fifo_seq_ctrl
    import fifo_seq_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int BITS  = DEF_BITS,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BITS-1:0]  in_data,
    input  logic             start,
    input  logic             scrub,
    output logic             fifo_en,
    output logic [BITS-1:0]  fifo_d,
    input  logic [BITS-1:0]  fifo_q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BITS-1:0]  out_data,
    output logic [CNT_W-1:0] count,
`ifdef FIFO_SEQ_CSUM_EN
    output logic [BITS-1:0]  csum,
    output logic             csum_valid,
`endif
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic             last_beat;

    assign last_beat = (beat_q == LAST);
    assign count     = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        beat_d    = beat_q;
        in_ready  = 1'b0;
        fifo_en   = 1'b0;
        fifo_d    = '0;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_IDLE, S_FILL: begin
                // Gated by rst_n so in_ready reads 0 while reset is held;
                // scrub wins over a same-cycle word.
                in_ready = rst_n & ~scrub;
                if (scrub) begin
                    state_d = S_SCRUB;
                    beat_d  = '0;
                end else if (in_valid && in_ready) begin
                    fifo_en = 1'b1;
                    fifo_d  = in_data;
                    count_d = count_q + 1'b1;
                    state_d = (count_q == LAST) ? S_FULL : S_FILL;
                end
            end
            S_FULL: begin
                if (scrub) begin
                    state_d = S_SCRUB;
                    beat_d  = '0;
                end else if (start) begin
                    state_d = S_DRAIN;
                    beat_d  = '0;
                end
            end
            S_DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = fifo_q;
                if (out_ready) begin
                    // Shift zeros in behind the drained word so the FIFO
                    // ends the drain empty of live data.
                    fifo_en = 1'b1;
                    done    = last_beat;
                    if (last_beat) begin
                        state_d = S_IDLE;
                        count_d = '0;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_SCRUB: begin
                busy    = 1'b1;
                fifo_en = 1'b1;
                done    = last_beat;
                if (last_beat) begin
                    state_d = S_IDLE;
                    count_d = '0;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef FIFO_SEQ_CSUM_EN
    logic [BITS-1:0] csum_q;
    logic            drain_beat;

    assign drain_beat = (state_q == S_DRAIN) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            csum_q <= '0;
        else if (state_q == S_FULL && start && !scrub)
            csum_q <= '0;
        else if (drain_beat)
            csum_q <= csum_q ^ fifo_q;
    end

    // Fold in the current beat so the full checksum is visible on the
    // done cycle; after the drain it is simply the held register.
    assign csum       = csum_q ^ (drain_beat ? fifo_q : '0);
    assign csum_valid = done && (state_q == S_DRAIN);
`endif

endmodule

// File: tb/tb_fifo_seq_ctrl.sv
module tb_fifo_seq_ctrl;
    localparam int DEPTH = 8;
    localparam int BITS  = 64;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [BITS-1:0]  in_data = '0;
    logic             start = 1'b0;
    logic             scrub = 1'b0;
    logic             fifo_en;
    logic [BITS-1:0]  fifo_d;
    logic [BITS-1:0]  fifo_q;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [BITS-1:0]  out_data;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;
`ifdef FIFO_SEQ_CSUM_EN
    logic [BITS-1:0]  csum;
    logic             csum_valid;
`endif

    int checks = 0;
    int errors = 0;
    logic [BITS-1:0] words [DEPTH];

    always #5 clk = ~clk;

    fifo_seq_ctrl #(.DEPTH(DEPTH), .BITS(BITS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .start(start), .scrub(scrub),
        .fifo_en(fifo_en), .fifo_d(fifo_d), .fifo_q(fifo_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count),
`ifdef FIFO_SEQ_CSUM_EN
        .csum(csum), .csum_valid(csum_valid),
`endif
        .busy(busy), .done(done)
    );

    // Flagless delay FIFO attached by the parent: shift on en, q = oldest.
    logic [BITS-1:0] fmem [DEPTH];
    assign fifo_q = fmem[DEPTH-1];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) fmem[i] <= '0;
        end else if (fifo_en) begin
            fmem[0] <= fifo_d;
            for (int i = 1; i < DEPTH; i++) fmem[i] <= fmem[i-1];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_fifo_en"}, 64'(fifo_en), 64'd0);
        chk({tag, "_fifo_d"}, fifo_d, 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_data"}, out_data, 64'd0);
        chk({tag, "_count"}, 64'(count), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
    endtask

    // Push words[0..n-1] from IDLE; with n==DEPTH also checks the hold-off cycle.
    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = words[i];
            #1;
            chk("fill_in_ready", 64'(in_ready), 64'd1);
            chk("fill_fifo_en", 64'(fifo_en), 64'd1);
            chk("fill_fifo_d", fifo_d, words[i]);
            chk("fill_count", 64'(count), 64'(i));
        end
        @(negedge clk);
        if (n == DEPTH) begin
            #1;
            chk("full_in_ready", 64'(in_ready), 64'd0);
            chk("full_fifo_en", 64'(fifo_en), 64'd0);
            chk("full_count", 64'(count), 64'(DEPTH));
            chk("full_busy", 64'(busy), 64'd0);
        end
        in_valid = 1'b0;
    endtask

    // Pulse start from FULL, then accept beats until `stop` words are taken.
    // pat 0: out_ready always 1; pat 1: 1,0,0,1 repeating.
    task automatic drain(input int pat, input int stop);
        int acc = 0;
        int cyc = 0;
        logic [BITS-1:0] xs = '0;
        @(negedge clk);
        start = 1'b1;
        #1;
        chk("start_out_valid", 64'(out_valid), 64'd0);
        while (acc < stop && cyc < 64) begin
            @(negedge clk);
            start = 1'b0;
            out_ready = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            #1;
            chk("drain_out_valid", 64'(out_valid), 64'd1);
            chk("drain_busy", 64'(busy), 64'd1);
            chk("drain_out_data", out_data, words[acc]);
            chk("drain_fifo_en", 64'(fifo_en), 64'(out_ready));
            chk("drain_done", 64'(done), 64'(out_ready && acc == DEPTH - 1));
            if (out_ready) xs = xs ^ words[acc];
`ifdef FIFO_SEQ_CSUM_EN
            chk("csum_valid", 64'(csum_valid), 64'(done));
            if (out_ready && acc == DEPTH - 1) chk("csum", csum, xs);
`endif
            if (out_ready) acc++;
            cyc++;
        end
        chk("drain_beats", 64'(acc), 64'(stop));
        if (stop == DEPTH) begin
            @(negedge clk);
            out_ready = 1'b0;
            #1;
            chk("post_out_valid", 64'(out_valid), 64'd0);
            chk("post_count", 64'(count), 64'd0);
            chk("post_in_ready", 64'(in_ready), 64'd1);
            chk("post_busy", 64'(busy), 64'd0);
`ifdef FIFO_SEQ_CSUM_EN
            chk("csum_hold", csum, xs);
            chk("csum_valid_off", 64'(csum_valid), 64'd0);
`endif
        end
    endtask

    initial begin
        // Reset, with in_valid asserted to show nothing leaks through.
        in_valid = 1'b1;
        #12;
        chk_reset_vals("reset");
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Full-rate fill and drain.
        for (int i = 0; i < DEPTH; i++) words[i] = 64'(8'h11 * (i + 1));
        fill(DEPTH);
        drain(0, DEPTH);

        // Stalling consumer.
        for (int i = 0; i < DEPTH; i++) words[i] = 64'hA000_0000_0000_0000 | 64'(i + 1);
        fill(DEPTH);
        drain(1, DEPTH);

        // Partial fill: start ignored, then scrub (with a competing word).
        for (int i = 0; i < DEPTH; i++) words[i] = 64'hDEAD_0000_0000_0000 | 64'(i);
        fill(3);
        @(negedge clk);
        start = 1'b1;
        #1;
        chk("partial_start_ov", 64'(out_valid), 64'd0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("partial_ov", 64'(out_valid), 64'd0);
        chk("partial_busy", 64'(busy), 64'd0);
        chk("partial_count", 64'(count), 64'd3);
        @(negedge clk);
        scrub = 1'b1;
        in_valid = 1'b1;
        in_data = 64'hBAD;
        #1;
        chk("scrub_in_ready", 64'(in_ready), 64'd0);
        chk("scrub_fifo_en0", 64'(fifo_en), 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            scrub = 1'b0;
            #1;
            chk("scrub_fifo_en", 64'(fifo_en), 64'd1);
            chk("scrub_fifo_d", fifo_d, 64'd0);
            chk("scrub_busy", 64'(busy), 64'd1);
            chk("scrub_out_valid", 64'(out_valid), 64'd0);
            chk("scrub_in_ready_b", 64'(in_ready), 64'd0);
            chk("scrub_done", 64'(done), 64'(i == DEPTH - 1));
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("scrub_end_count", 64'(count), 64'd0);
        chk("scrub_end_busy", 64'(busy), 64'd0);
        chk("scrub_end_done", 64'(done), 64'd0);
        for (int i = 0; i < DEPTH; i++) words[i] = 64'h5500_0000_0000_0000 | 64'(i * 3);
        fill(DEPTH);
        drain(1, DEPTH);

        // Reset after 4 drain beats, then a fresh fill/drain.
        for (int i = 0; i < DEPTH; i++) words[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
        fill(DEPTH);
        drain(0, 4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) words[i] = 64'h7700_0000_0000_0000 | 64'(i + 9);
        fill(DEPTH);
        drain(0, DEPTH);

        // One-hot words: checksum 0xFF in checksum builds.
        for (int i = 0; i < DEPTH; i++) words[i] = 64'(1) << i;
        fill(DEPTH);
        drain(0, DEPTH);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_seq_ctrl.md
Name: fifo_seq_ctrl

Overview:
Upstream sequencer for the 64-bit delay FIFO lane, which has no flags of its own. It accepts words over a valid/ready interface and pushes them into the FIFO by driving its enable and data inputs. It tracks occupancy and, on command, drains exactly DEPTH words to a downstream valid/ready consumer. A scrub command refills the FIFO with zeros without producing output.

Parameters:
DEPTH, 8, entries in the attached delay FIFO; must equal that FIFO's DEPTH
BITS, 64, word width
CNT_W, $clog2(DEPTH+1), occupancy/beat counter width

Ports:
clk  input  1  clock
rst_n  input  1  reset; asynchronous, active-low
in_valid  input  1  upstream word valid
in_ready  output  1  controller can accept a word
in_data  input  BITS  upstream word
start  input  1  single-cycle pulse: begin draining
scrub  input  1  single-cycle pulse: zero-fill the FIFO, no output
fifo_en  output  1  to FIFO en; one shift per asserted cycle
fifo_d  output  BITS  to FIFO d
fifo_q  input  BITS  from FIFO q (oldest entry, combinational)
out_valid  output  1  drained word valid
out_ready  input  1  downstream accepts
out_data  output  BITS  drained word
count  output  CNT_W  current occupancy, 0..DEPTH
busy  output  1  state is DRAIN or SCRUB
done  output  1  one-cycle pulse on the final drain or scrub beat

Behaviour:
- Reset values: state IDLE, count=0, beat=0, in_ready=0, fifo_en=0, fifo_d=0, out_valid=0, out_data=0, busy=0, done=0. The FIFO shares rst_n, so both blocks start with all-zero contents.
- States: IDLE, FILL, FULL, DRAIN, SCRUB. Outputs are decoded from registered state and counters; no input-to-output combinational path except those listed below.
- IDLE/FILL:
  - in_ready=1.
  - On in_valid & in_ready: fifo_en=1 and fifo_d=in_data in the same cycle (combinational), count++. The state becomes FILL after the first word.
  - When count reaches DEPTH, go to FULL on the next cycle. in_ready is then 0.
- FULL:
  - in_ready=0. Extra in_valid is held off, not dropped.
  - start moves to DRAIN with beat=0.
- DRAIN:
  - out_valid=1 and out_data=fifo_q, combinational from fifo_q.
  - On out_ready: fifo_en=1, fifo_d=0, beat++.
  - On the beat where beat==DEPTH-1 and out_ready: done=1. Next cycle: IDLE, count=0.
  - Without out_ready the FIFO does not shift and out_data holds.
  - Words emerge in write order, first word first.
- SCRUB:
  - fifo_en=1 and fifo_d=0 every cycle for DEPTH cycles. out_valid=0, in_ready=0.
  - done pulses on the final cycle. Next cycle: IDLE, count=0.
- start rules:
  - Ignored in IDLE, FILL, DRAIN and SCRUB; it is not queued.
  - start in FILL with count<DEPTH is ignored; a partial drain is not supported.
- scrub rules:
  - Accepted in IDLE, FILL and FULL; ignored in DRAIN and SCRUB.
  - scrub has priority over in_valid and start in the same cycle. That cycle's input word is not accepted, and in_ready is deasserted combinationally when scrub=1.
- Reset mid-operation: asynchronous return to reset values. A partially drained or scrubbed FIFO is cleared by the same rst_n.
- Counters saturate by construction: count never exceeds DEPTH, and beat never exceeds DEPTH-1.

Optional Feature:
FIFO_SEQ_CSUM_EN
- Defined: adds outputs csum (BITS) and csum_valid (1).
  - csum clears to 0 on entry to DRAIN.
  - On every accepted drain beat, csum <= csum ^ out_data.
  - csum_valid pulses together with done (DRAIN only, not SCRUB). csum then holds until the next DRAIN.
  - Reset value 0.
- Undefined: the ports, registers and logic are absent; all other behaviour is identical.

Decomposition:
- Package fifo_seq_pkg holds the state enum (IDLE, FILL, FULL, DRAIN, SCRUB) and the default-width localparams.
- No sub-module: a single FSM plus two counters. The delay FIFO is instantiated alongside this block by the parent, not inside it.

Test Plan:
- Fill 8 words 0x11..0x88 with in_valid held high -> in_ready high for exactly 8 accepts, count=8, state FULL, in_ready=0 on cycle 9.
- FULL, pulse start, out_ready=1 -> out_data 0x11,0x22,...,0x88 on 8 consecutive cycles; done on the 0x88 beat; count=0 and in_ready=1 next cycle.
- DRAIN with out_ready toggled 1,0,0,1,... -> no fifo_en while out_ready=0, out_data stable; all 8 words delivered in order; done only on the 8th accepted beat.
- Fill 3 words, pulse start -> ignored (no out_valid). Then pulse scrub -> fifo_en high 8 cycles with fifo_d=0, done once. Refill with 8 new words and drain -> only the new words appear.
- Assert rst_n low mid-DRAIN after 4 beats -> all outputs at reset values immediately. A fresh fill/drain afterwards returns the new data with no stale words.
- With FIFO_SEQ_CSUM_EN: drain 0x1,0x2,0x4,...,0x80 -> csum=0xFF with csum_valid coincident with done.
